// File: rtl/sram_banked_rw_wrapper.sv
// 1W1R word memory tiled from 32x1024 macros, with byte-masked writes and same-address forwarding.
// Read latency 1 (q/q_valid/collision/addr_err aligned); no backpressure, one request per port per cycle.

module sram_macro_1rw1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk0,
  input  logic                     csb0,
  input  logic                     web0,
  input  logic [WIDTH/8-1:0]       wmask0,
  input  logic [$clog2(DEPTH)-1:0] addr0,
  input  logic [WIDTH-1:0]         din0,
  input  logic                     clk1,
  input  logic                     csb1,
  input  logic [$clog2(DEPTH)-1:0] addr1,
  output logic [WIDTH-1:0]         dout1
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) begin
      for (int k = 0; k < WIDTH/8; k++) begin
        if (wmask0[k]) mem[addr0][8*k +: 8] <= din0[8*k +: 8];
      end
    end
  end

  // A same-edge write is not visible here; the wrapper's forwarding path covers that case.
  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end
endmodule

module sram_banked_rw_wrapper #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 8192,
  parameter int ADDR_WIDTH  = 13,
  parameter int MACRO_WIDTH = 32,
  parameter int MACRO_DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wadr,
  input  logic [DATA_WIDTH-1:0]   d,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   radr,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  output logic                    collision,
  output logic                    addr_err
);
  localparam int ROW_W     = $clog2(MACRO_DEPTH);
  localparam int BANK_W    = ADDR_WIDTH - ROW_W;
  localparam int NUM_BANKS = DEPTH / MACRO_DEPTH;
  localparam int NUM_COLS  = DATA_WIDTH / MACRO_WIDTH;
  localparam int MASK_W    = DATA_WIDTH / 8;
  localparam int MMASK_W   = MACRO_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  if (DATA_WIDTH % MACRO_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of MACRO_WIDTH");
  end
  if (DEPTH % MACRO_DEPTH != 0) begin : g_bad_depth
    $error("DEPTH must be a multiple of MACRO_DEPTH");
  end

  logic                  wr_in, rd_in, wr_ok, rd_ok, wr_bad, rd_bad, same_adr;
  logic [BANK_W-1:0]     wbank, rbank_nxt, rbank;
  logic [ROW_W-1:0]      wrow, rrow;
  logic [DATA_WIDTH-1:0] wbits, fwd_d, fwd_m, rd_word, merged;
  logic                  rd_pend, oob_pend, coll_pend, err_pend;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_dout;

  assign wr_in     = ({1'b0, wadr} < DEPTH_W);
  assign rd_in     = ({1'b0, radr} < DEPTH_W);
  assign wr_ok     = rst_n & we & wr_in;
  assign rd_ok     = rst_n & re & rd_in;
  assign wr_bad    = rst_n & we & ~wr_in;
  assign rd_bad    = rst_n & re & ~rd_in;
  assign same_adr  = (wadr == radr);
  assign wbank     = wadr[ADDR_WIDTH-1:ROW_W];
  assign wrow      = wadr[ROW_W-1:0];
  assign rbank_nxt = radr[ADDR_WIDTH-1:ROW_W];
  assign rrow      = radr[ROW_W-1:0];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [BANK_W-1:0] BIDX = BANK_W'(b);
    logic wsel, rsel;
    assign wsel = wr_ok && (wbank == BIDX);
    assign rsel = rd_ok && (rbank_nxt == BIDX);
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      sram_macro_1rw1r #(.WIDTH(MACRO_WIDTH), .DEPTH(MACRO_DEPTH)) u_macro (
        .clk0   (clk),
        .csb0   (~wsel),
        .web0   (~wsel),
        .wmask0 (wmask[c*MMASK_W +: MMASK_W]),
        .addr0  (wrow),
        .din0   (d[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .clk1   (clk),
        .csb1   (~rsel),
        .addr1  (rrow),
        .dout1  (bank_dout[b][c*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  always_comb begin
    wbits = '0;
    for (int k = 0; k < MASK_W; k++) wbits[8*k +: 8] = {8{wmask[k]}};
  end

  // Output mux follows the bank captured with the request, not the live read address.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rbank == BANK_W'(b)) rd_word = bank_dout[b];
    end
  end

  assign merged = coll_pend ? ((fwd_d & fwd_m) | (rd_word & ~fwd_m)) : rd_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= '0;
      q_valid   <= 1'b0;
      collision <= 1'b0;
      addr_err  <= 1'b0;
      rd_pend   <= 1'b0;
      oob_pend  <= 1'b0;
      coll_pend <= 1'b0;
      err_pend  <= 1'b0;
      rbank     <= '0;
      fwd_d     <= '0;
      fwd_m     <= '0;
    end else begin
      rd_pend   <= rd_ok;
      oob_pend  <= rd_bad;
      coll_pend <= rd_ok & wr_ok & same_adr;
      err_pend  <= rd_bad | wr_bad;
      if (rd_ok) rbank <= rbank_nxt;
      if (rd_ok && wr_ok && same_adr) begin
        fwd_d <= d;
        fwd_m <= wbits;
      end
      q_valid   <= rd_pend | oob_pend;
      collision <= coll_pend;
      addr_err  <= err_pend;
      if (rd_pend)       q <= merged;
      else if (oob_pend) q <= '0;
    end
  end
endmodule

// File: tb/tb_sram_banked_rw_wrapper.sv
// Directed bench for sram_banked_rw_wrapper (DEPTH=6144 so the out-of-range window exists).
module tb_sram_banked_rw_wrapper;
  localparam int DW = 128;
  localparam int AW = 13;
  localparam int DEPTH = 6144;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we, re;
  logic [AW-1:0] wadr, radr;
  logic [DW-1:0] d;
  logic [15:0]   wmask;
  logic [DW-1:0] q;
  logic          q_valid, collision, addr_err;

  int errors = 0;
  int checks = 0;

  sram_banked_rw_wrapper #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MACRO_WIDTH(32), .MACRO_DEPTH(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wadr(wadr), .d(d), .wmask(wmask),
    .re(re), .radr(radr), .q(q), .q_valid(q_valid), .collision(collision), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: a word array; a read returns the word as it stands after that edge's write.
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_q, pend_q, cur;
  logic exp_v, exp_c, exp_e, pend_v, pend_c, pend_e;
  bit started = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1;
      exp_q = '0; exp_v = 0; exp_c = 0; exp_e = 0;
      pend_q = '0; pend_v = 0; pend_c = 0; pend_e = 0;
    end else begin
      exp_v = pend_v; exp_c = pend_c; exp_e = pend_e;
      if (pend_v) exp_q = pend_q;
      pend_e = (we && int'(wadr) >= DEPTH) || (re && int'(radr) >= DEPTH);
      pend_c = we && re && (wadr == radr) && int'(wadr) < DEPTH;
      if (we && int'(wadr) < DEPTH) begin
        cur = model_mem.exists(int'(wadr)) ? model_mem[int'(wadr)] : '0;
        for (int k = 0; k < 16; k++) if (wmask[k]) cur[8*k +: 8] = d[8*k +: 8];
        model_mem[int'(wadr)] = cur;
      end
      pend_v = re;
      if (re) pend_q = (int'(radr) < DEPTH && model_mem.exists(int'(radr))) ? model_mem[int'(radr)] : '0;
    end
    #1;
    if (started) begin
      chk("model_q", q, exp_q);
      chk("model_q_valid", DW'(q_valid), DW'(exp_v));
      chk("model_collision", DW'(collision), DW'(exp_c));
      chk("model_addr_err", DW'(addr_err), DW'(exp_e));
    end
  end

  task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] dd,
                     input logic [15:0] m, input logic r, input logic [AW-1:0] ra, input logic rs);
    @(negedge clk);
    we = w; wadr = wa; d = dd; wmask = m; re = r; radr = ra; rst_n = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  localparam logic [DW-1:0] C1   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] XV   = 128'h11112222333344445555666677778888;
  localparam logic [DW-1:0] YV   = 128'h99990000AAAABBBBCCCCDDDDEEEEFFFF;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] AAS  = {16{8'hAA}};
  localparam logic [DW-1:0] FIVES = {16{8'h55}};

  initial begin
    rst_n = 1'b0; we = 0; re = 0; wadr = '0; radr = '0; d = '0; wmask = '0;
    cyc(0, '0, '0, '0, 0, '0, 1'b0);
    cyc(0, '0, '0, '0, 0, '0, 1'b0);
    chk("reset_q", q, '0);
    chk("reset_q_valid", DW'(q_valid), '0);
    chk("reset_flags", DW'({collision, addr_err}), '0);

    // 1: full write then read, latency one
    cyc(1, 13'h000, C1, 16'hFFFF, 0, '0, 1);
    cyc(0, '0, '0, '0, 1, 13'h000, 1);
    chk("t1_no_valid_at_E", DW'(q_valid), '0);
    idle();
    chk("t1_q", q, C1);
    chk("t1_valid", DW'(q_valid), 128'd1);
    idle();
    chk("t1_hold_q", q, C1);
    chk("t1_valid_drop", DW'(q_valid), '0);

    // 2: bank boundary, back-to-back reads
    cyc(1, 13'h3FF, XV, 16'hFFFF, 0, '0, 1);
    cyc(1, 13'h400, YV, 16'hFFFF, 0, '0, 1);
    cyc(0, '0, '0, '0, 1, 13'h3FF, 1);
    cyc(0, '0, '0, '0, 1, 13'h400, 1);
    chk("t2_q_3ff", q, XV);
    idle();
    chk("t2_q_400", q, YV);

    // 3: partial mask rewrite
    cyc(1, 13'h010, ONES, 16'hFFFF, 0, '0, 1);
    cyc(1, 13'h010, '0, 16'h00FF, 0, '0, 1);
    cyc(0, '0, '0, '0, 1, 13'h010, 1);
    idle();
    chk("t3_q", q, {64'hFFFFFFFFFFFFFFFF, 64'h0});

    // 4: same-address write and read forward the merged word
    cyc(1, 13'h020, AAS, 16'hFFFF, 0, '0, 1);
    cyc(1, 13'h020, FIVES, 16'h0F0F, 1, 13'h020, 1);
    idle();
    chk("t4_q_merged", q, 128'hAAAAAAAA55555555AAAAAAAA55555555);
    chk("t4_collision", DW'(collision), 128'd1);
    cyc(0, '0, '0, '0, 1, 13'h020, 1);
    idle();
    chk("t4_q_reread", q, 128'hAAAAAAAA55555555AAAAAAAA55555555);
    chk("t4_no_collision", DW'(collision), '0);

    // 5: out-of-range write and read
    cyc(1, 13'h1800, YV, 16'hFFFF, 0, '0, 1);
    idle();
    chk("t5_werr", DW'(addr_err), 128'd1);
    cyc(0, '0, '0, '0, 1, 13'h000, 1);
    cyc(0, '0, '0, '0, 1, 13'h1800, 1);
    chk("t5_q_000_unchanged", q, C1);
    idle();
    chk("t5_oob_q", q, '0);
    chk("t5_oob_flags", DW'({q_valid, addr_err}), 128'd3);

    // 6: reset lands on the result edge of a read
    cyc(0, '0, '0, '0, 1, 13'h3FF, 1);
    idle();
    chk("t6_pre_q", q, XV);
    cyc(0, '0, '0, '0, 1, 13'h3FF, 1);
    cyc(0, '0, '0, '0, 0, '0, 0);
    chk("t6_reset_q", q, '0);
    chk("t6_reset_valid", DW'(q_valid), '0);
    idle();
    idle();
    chk("t6_after_valid", DW'(q_valid), '0);
    chk("t6_after_q", q, '0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
